photon_pulse_counter: RTL

Gated photon pulse counter that feeds the draw scheduling stage. It synchronises the raw detector pulse into `clk` and counts rising edges over a fixed gate window selected by `iMode`. At the end of each window it publishes the window count with a one-cycle update strobe, and it maintains a saturating accumulated total. Its outputs connect directly to the draw adapter's `iPulse_Counter`, `iData_Update` and `iPulseCounter_Accumulated` inputs.

---
 rtl/photon_pulse_counter_pkg.sv | 27 ++
 rtl/photon_pulse_counter_edge_sync.sv | 32 +++
 rtl/photon_pulse_counter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/photon_pulse_counter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | photon_pkg : shared FSM encoding, saturation limit and window defaults    |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
package photon_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARM   = 2'd1;
  localparam logic [1:0] ST_COUNT = 2'd2;

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  localparam int unsigned WIN_LEN0_DEF = 50_000_000;
  localparam int unsigned WIN_LEN1_DEF = 5_000_000;
  localparam int unsigned WIN_LEN2_DEF = 500_000;
  localparam int unsigned WIN_LEN3_DEF = 50_000;

  // Bit 32 of the result flags that the sum was clamped to CNT_MAX.
  function automatic logic [32:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? {1'b1, CNT_MAX} : s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/photon_pulse_counter_edge_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pulse_edge_sync : 2-FF synchroniser plus rising-edge detector             |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
module pulse_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic iPulse,
  output logic edge_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= iPulse;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign edge_o = sync2_q & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/photon_pulse_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | photon_pulse_counter : gated photon pulse counter with saturating total   |
// | Optional dead-time filter: define PHOTON_DEADTIME_EN.   Rev 1.0            |
// +--------------------------------------------------------------------------+
module photon_pulse_counter
  import photon_pkg::*;
#(
  parameter int unsigned WIN_LEN0 = WIN_LEN0_DEF,
  parameter int unsigned WIN_LEN1 = WIN_LEN1_DEF,
  parameter int unsigned WIN_LEN2 = WIN_LEN2_DEF,
  parameter int unsigned WIN_LEN3 = WIN_LEN3_DEF,
  parameter int unsigned DEADTIME = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [1:0]  iMode,
  input  logic        iPulse,
  input  logic        iClear,
  output logic [31:0] oPulse_Counter,
  output logic        oData_Update,
  output logic [31:0] oPulseCounter_Accumulated,
  output logic        oOverflow
);

`ifdef PHOTON_DEADTIME_EN
  localparam bit DT_EN = 1'b1;
`else
  localparam bit DT_EN = 1'b0;
`endif

  logic        w_edge;
  logic        w_accept;
  logic [1:0]  state_q,   state_d;
  logic [31:0] timer_q,   timer_d;
  logic [31:0] win_cnt_q, win_cnt_d;
  logic [31:0] cnt_out_q, cnt_out_d;
  logic [31:0] acc_q,     acc_d;
  logic        upd_q,     upd_d;
  logic        ovf_q,     ovf_d;
  logic        win_sat_q, win_sat_d;
  logic [32:0] w_win_sum;
  logic [32:0] w_acc_sum;
  logic [31:0] w_acc_base;
  logic        w_ovf_base;

  pulse_edge_sync u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .iPulse (iPulse),
    .edge_o (w_edge)
  );

  function automatic logic [31:0] win_len_m1(input logic [1:0] m);
    case (m)
      2'd0:    return 32'(WIN_LEN0) - 32'd1;
      2'd1:    return 32'(WIN_LEN1) - 32'd1;
      2'd2:    return 32'(WIN_LEN2) - 32'd1;
      default: return 32'(WIN_LEN3) - 32'd1;
    endcase
  endfunction

  // Dead-time window is held clear outside COUNT so every window start is fresh.
  if (DT_EN && (DEADTIME > 0)) begin : g_deadtime
    localparam int unsigned DT_W = $clog2(DEADTIME + 1);
    logic [DT_W-1:0] dead_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                     dead_q <= '0;
      else if (state_q != ST_COUNT)   dead_q <= '0;
      else if (w_accept)              dead_q <= DT_W'(DEADTIME - 1);
      else if (dead_q != '0)          dead_q <= dead_q - DT_W'(1);
    end

    assign w_accept = w_edge && (dead_q == '0);
  end else begin : g_no_deadtime
    assign w_accept = w_edge;
  end

  always_comb begin
    w_win_sum  = sat_add(win_cnt_q, {31'd0, w_accept});
    w_acc_base = iClear ? 32'd0 : acc_q;
    w_ovf_base = iClear ? 1'b0 : ovf_q;
    w_acc_sum  = sat_add(w_acc_base, w_win_sum[31:0]);

    state_d   = state_q;
    timer_d   = timer_q;
    win_cnt_d = win_cnt_q;
    win_sat_d = win_sat_q;
    cnt_out_d = cnt_out_q;
    acc_d     = w_acc_base;
    ovf_d     = w_ovf_base;
    upd_d     = 1'b0;

    case (state_q)
      ST_ARM: begin
        timer_d   = win_len_m1(iMode);
        win_cnt_d = 32'd0;
        win_sat_d = 1'b0;
        state_d   = ST_COUNT;
      end
      ST_COUNT: begin
        if (timer_q == 32'd0) begin
          // A clear in this cycle leaves only this window's own saturation visible.
          cnt_out_d = w_win_sum[31:0];
          upd_d     = 1'b1;
          acc_d     = w_acc_sum[31:0];
          ovf_d     = w_ovf_base | win_sat_q | w_win_sum[32] | w_acc_sum[32];
          timer_d   = win_len_m1(iMode);
          win_cnt_d = 32'd0;
          win_sat_d = 1'b0;
        end else begin
          timer_d   = timer_q - 32'd1;
          win_cnt_d = w_win_sum[31:0];
          win_sat_d = win_sat_q | w_win_sum[32];
          ovf_d     = w_ovf_base | w_win_sum[32];
        end
      end
      default: begin
        timer_d   = 32'd0;
        win_cnt_d = 32'd0;
        win_sat_d = 1'b0;
        if (en) state_d = ST_ARM;
      end
    endcase

    if (!en) begin
      state_d   = ST_IDLE;
      timer_d   = 32'd0;
      win_cnt_d = 32'd0;
      win_sat_d = 1'b0;
      cnt_out_d = cnt_out_q;
      acc_d     = w_acc_base;
      ovf_d     = w_ovf_base;
      upd_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      timer_q   <= 32'd0;
      win_cnt_q <= 32'd0;
      win_sat_q <= 1'b0;
      cnt_out_q <= 32'd0;
      acc_q     <= 32'd0;
      upd_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      win_cnt_q <= win_cnt_d;
      win_sat_q <= win_sat_d;
      cnt_out_q <= cnt_out_d;
      acc_q     <= acc_d;
      upd_q     <= upd_d;
      ovf_q     <= ovf_d;
    end
  end

  assign oPulse_Counter            = cnt_out_q;
  assign oData_Update              = upd_q;
  assign oPulseCounter_Accumulated = acc_q;
  assign oOverflow                 = ovf_q;

endmodule
`default_nettype wire
